w_addr_seq: RTL

Parametrised, sequenced write-address generator for the SCAN polar decoder datapath. Accepts one node command (unit type, layer size) per handshake and selects the alpha or beta bank the node writes. It then emits one registered bank/offset beat per PE-group write until the half-layer is covered. It sits between the scheduler and the alpha/beta memory write ports. It replaces the fixed 1024-point combinational mapping with a code-length- and parallelism-generic sequencer with valid/ready flow control.

---
 rtl/w_addr_seq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/w_addr_seq.sv
// Write-address sequencer for the SCAN polar decoder: latches one node command,
// picks the alpha/beta write bank and streams one offset beat per PE-group write.
module w_addr_seq #(
   parameter int N_LOG = 10,
   parameter int P_LOG = 3,
   localparam int BW = $clog2(N_LOG + 1),
   localparam int OW = ((N_LOG - P_LOG - 1) > 1) ? (N_LOG - P_LOG - 1) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_type,
   input  logic [N_LOG:0]   cmd_layer,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BW-1:0]    w_a,
   output logic [BW-1:0]    w_b,
   output logic [OW-1:0]    w_off,
   output logic             w_last,
   output logic             err
);

   localparam int LW = N_LOG + 1;
   localparam logic [3:0] T_TYPE1 = 4'b0000;
   localparam logic [3:0] T_TYPE2 = 4'b0001;
   localparam logic [3:0] T_TYPE3 = 4'b0011;

   typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t          state_r, state_nxt_s;
   logic            cmd_ready_s, out_valid_s, accept_s, consume_s;
   logic            layer_ok_s;
   logic [BW-1:0]   l_s, map_a_s, map_b_s;
   logic [LW-1:0]   eff_layer_s, shifted_s;
   logic [OW-1:0]   beat_bm1_s, map_bm1_s;
   logic [BW-1:0]   w_a_r, w_b_r;
   logic [OW-1:0]   w_off_r, bm1_r;
   logic            w_last_r, err_r;

   function automatic logic is_pow2(input logic [LW-1:0] v);
      return (v != LW'(0)) && ((v & (v - LW'(1))) == LW'(0));
   endfunction

   function automatic logic [BW-1:0] layer_log2(input logic [LW-1:0] v);
      logic [BW-1:0] r;
      r = BW'(0);
      for (int i = 0; i < LW; i++) begin
         if (v[i]) r = BW'(i);
      end
      return r;
   endfunction

   // Bank and beat-count mapping of the command currently on the cmd bus.
   always_comb begin
      layer_ok_s  = is_pow2(cmd_layer);
      l_s         = layer_ok_s ? layer_log2(cmd_layer) : BW'(0);
      // An illegal layer behaves like a single-element node (L=0).
      eff_layer_s = layer_ok_s ? cmd_layer : LW'(1);
      shifted_s   = eff_layer_s >> (P_LOG + 1);
      beat_bm1_s  = (shifted_s == LW'(0)) ? OW'(0) : OW'(shifted_s - LW'(1));
      map_a_s     = BW'(0);
      map_b_s     = BW'(0);
      map_bm1_s   = OW'(0);
      case (cmd_type)
         T_TYPE1, T_TYPE2: begin
            map_bm1_s = beat_bm1_s;
            if (l_s >= BW'(2)) map_a_s = l_s - BW'(1);
            else               map_a_s = BW'(0);
         end
         T_TYPE3: begin
            map_bm1_s = beat_bm1_s;
            if ((l_s >= BW'(2)) && (l_s <= BW'(N_LOG - 1))) map_b_s = l_s;
            else                                            map_b_s = BW'(0);
         end
         default: begin
            map_b_s = BW'(1);
         end
      endcase
   end

   // Next state and handshake decode.
   always_comb begin
      state_nxt_s = state_r;
      cmd_ready_s = 1'b0;
      out_valid_s = 1'b0;
      case (state_r)
         IDLE: begin
            cmd_ready_s = 1'b1;
            if (cmd_valid) state_nxt_s = RUN;
            else           state_nxt_s = IDLE;
         end
         RUN: begin
            out_valid_s = 1'b1;
            // Ready on the last consumed beat so the next command follows without a bubble.
            cmd_ready_s = out_ready & w_last_r;
            if (out_ready && w_last_r) state_nxt_s = cmd_valid ? RUN : IDLE;
            else                       state_nxt_s = RUN;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   assign accept_s  = cmd_valid & cmd_ready_s;
   assign consume_s = out_valid_s & out_ready;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= IDLE;
      else     state_r <= state_nxt_s;
   end

   // Per-command latches, offset counter and sticky error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_a_r    <= BW'(0);
         w_b_r    <= BW'(0);
         bm1_r    <= OW'(0);
         w_off_r  <= OW'(0);
         w_last_r <= 1'b0;
         err_r    <= 1'b0;
      end else if (accept_s) begin
         w_a_r    <= map_a_s;
         w_b_r    <= map_b_s;
         bm1_r    <= map_bm1_s;
         w_off_r  <= OW'(0);
         w_last_r <= (map_bm1_s == OW'(0));
         err_r    <= err_r | ~layer_ok_s;
      end else if (consume_s) begin
         if (w_last_r) begin
            w_off_r  <= OW'(0);
            w_last_r <= 1'b0;
         end else begin
            w_off_r  <= w_off_r + OW'(1);
            w_last_r <= ((w_off_r + OW'(1)) == bm1_r);
         end
      end else begin
         w_off_r  <= w_off_r;
         w_last_r <= w_last_r;
      end
   end

   assign cmd_ready = cmd_ready_s & ~rst;
   assign out_valid = out_valid_s;
   assign w_a       = w_a_r;
   assign w_b       = w_b_r;
   assign w_off     = w_off_r;
   assign w_last    = w_last_r;
   assign err       = err_r;

endmodule
